stream_demux1_2: RTL

STREAM_DEMUX1_2 -- requirements
Module: stream_demux1_2

---
 rtl/stream_demux1_2.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/stream_demux1_2.sv
//==============================================================================
// Module   : stream_demux1_2
// Purpose  : 1-to-2 valid/ready stream demultiplexer. Each accepted input beat
//            is routed by 'sel' (0 -> channel 1, 1 -> channel 2) into that
//            channel's own 2-entry FIFO. The two channels are fully
//            independent, so a stalled sink on one channel never blocks
//            traffic selected to the other channel.
//
// Ports    : sys_clk     in   clock, rising-edge active
//            sys_rst_n   in   asynchronous active-low reset
//            in_data     in   [DATA_W] input payload
//            in_valid    in   input payload valid
//            in_ready    out  input accepted this cycle (registered state + sel)
//            sel         in   route select, sampled with the input transfer
//            out1_data   out  [DATA_W] channel 1 FIFO head
//            out1_valid  out  channel 1 FIFO not empty
//            out1_ready  in   channel 1 sink ready
//            out2_data   out  [DATA_W] channel 2 FIFO head
//            out2_valid  out  channel 2 FIFO not empty
//            out2_ready  in   channel 2 sink ready
//            cnt1, cnt2  out  [16] completed output transfers per channel
//                             (only when DEMUX_CNT_EN is defined)
//
// Options  : DEMUX_CNT_EN - adds the wrapping 16-bit per-channel transfer
//                           counters and their output ports.
//
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module stream_demux1_2 #(
    parameter int DATA_W = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sel,
    output logic [DATA_W-1:0] out1_data,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [DATA_W-1:0] out2_data,
    output logic              out2_valid,
    input  logic              out2_ready
`ifdef DEMUX_CNT_EN
    ,
    output logic [15:0]       cnt1,
    output logic [15:0]       cnt2
`endif
);

    // Channel occupancy states; the encoding equals the entry count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    localparam int c_NCH = 2;

    // Per-channel views (index 0 = channel 1, index 1 = channel 2)
    logic [c_NCH-1:0]  w_sel_ch;   // one-hot decode of sel
    logic [c_NCH-1:0]  w_sink_rdy; // sink ready per channel
    logic [c_NCH-1:0]  w_full;     // channel holds two entries
    logic [c_NCH-1:0]  w_valid;    // channel holds at least one entry
    logic [c_NCH-1:0]  w_push;     // input beat written into channel
    logic [c_NCH-1:0]  w_pop;      // head beat taken by channel sink
    logic [DATA_W-1:0] w_head [c_NCH];

    assign w_sel_ch   = {sel, ~sel};
    assign w_sink_rdy = {out2_ready, out1_ready};

    // Readiness depends only on the selected channel's registered fullness,
    // never on the sinks' ready inputs. A full channel that is being drained
    // this cycle still refuses input; that keeps in_ready free of any
    // combinational path from out<n>_ready.
    assign in_ready = sel ? ~w_full[1] : ~w_full[0];

    generate
        for (genvar gi = 0; gi < c_NCH; gi++) begin : g_ch
            state_t            r_state;
            state_t            w_state_nxt;
            logic [DATA_W-1:0] r_head;  // entry presented to the sink
            logic [DATA_W-1:0] r_tail;  // second entry, valid only in ST_TWO

            assign w_full[gi]  = (r_state == ST_TWO);
            assign w_valid[gi] = (r_state != ST_EMPTY);
            assign w_head[gi]  = r_head;
            assign w_push[gi]  = in_valid & in_ready & w_sel_ch[gi];
            assign w_pop[gi]   = w_valid[gi] & w_sink_rdy[gi];

            // Next-state logic
            always_comb begin
                w_state_nxt = r_state;
                case (r_state)
                    ST_EMPTY: begin
                        if (w_push[gi]) begin
                            w_state_nxt = ST_ONE;
                        end
                    end
                    ST_ONE: begin
                        if (w_push[gi] && !w_pop[gi]) begin
                            w_state_nxt = ST_TWO;
                        end else if (w_pop[gi] && !w_push[gi]) begin
                            w_state_nxt = ST_EMPTY;
                        end
                    end
                    ST_TWO: begin
                        // A push cannot happen here because in_ready is low
                        // whenever this channel is both full and selected.
                        if (w_pop[gi]) begin
                            w_state_nxt = ST_ONE;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_EMPTY;
                    end
                endcase
            end

            // State register
            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    r_state <= ST_EMPTY;
                end else begin
                    r_state <= w_state_nxt;
                end
            end

            // Storage. The head only changes when it is empty or being
            // popped, so a presented beat stays stable until it is taken.
            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    r_head <= '0;
                    r_tail <= '0;
                end else begin
                    case (r_state)
                        ST_EMPTY: begin
                            if (w_push[gi]) begin
                                r_head <= in_data;
                            end
                        end
                        ST_ONE: begin
                            if (w_push[gi]) begin
                                if (w_pop[gi]) begin
                                    // Head leaves and is replaced in the same cycle
                                    r_head <= in_data;
                                end else begin
                                    r_tail <= in_data;
                                end
                            end
                        end
                        ST_TWO: begin
                            if (w_pop[gi]) begin
                                r_head <= r_tail;
                            end
                        end
                        default: begin
                            r_head <= r_head;
                        end
                    endcase
                end
            end
        end
    endgenerate

    assign out1_data  = w_head[0];
    assign out1_valid = w_valid[0];
    assign out2_data  = w_head[1];
    assign out2_valid = w_valid[1];

`ifdef DEMUX_CNT_EN
    // Completed output transfers per channel; 16-bit natural wrap.
    logic [15:0] r_cnt [c_NCH];

    generate
        for (genvar gc = 0; gc < c_NCH; gc++) begin : g_cnt
            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    r_cnt[gc] <= 16'd0;
                end else if (w_pop[gc]) begin
                    r_cnt[gc] <= r_cnt[gc] + 16'd1;
                end
            end
        end
    endgenerate

    assign cnt1 = r_cnt[0];
    assign cnt2 = r_cnt[1];
`endif

endmodule

`default_nettype wire
